// File: rtl/ifetch32.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake into
// the IF/ID register, and redirects on decoder branches.
//
// state | meaning
// START | post-reset idle, no request, acks ignored
// FETCH | request outstanding at areq
// HOLD  | acked word parked in skid buffer while downstream stalls
// DRAIN | wrong-path request still outstanding; its data is dropped
module ifetch32 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        ib_in,
    input  logic        bl_in,
    input  logic [31:0] bv_in,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] iout,
    output logic [31:0] pc_out,
    output logic        valid_out,
    output logic [31:0] lr_out,
    output logic        lr_we
);

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]  state;
    logic [31:0] fpc;
    logic [31:0] areq;
    logic [31:0] skid;
    logic        br_take;
    logic [31:0] br_target;

    assign br_take   = ib_in && valid_out && !stall_in;
    assign br_target = pc_out + 32'd8 + bv_in;
    assign imem_req  = (state == ST_FETCH) || (state == ST_DRAIN);
    assign imem_addr = areq;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_START;
            fpc       <= RESET_PC;
            areq      <= RESET_PC;
            skid      <= 32'd0;
            iout      <= 32'd0;
            pc_out    <= 32'd0;
            valid_out <= 1'b0;
            lr_out    <= 32'd0;
            lr_we     <= 1'b0;
        end else begin
            lr_we <= br_take && bl_in;
            if (br_take) begin
                lr_out <= pc_out + 32'd4;
                fpc    <= br_target;
            end

            case (state)
                ST_START: begin
                    state <= ST_FETCH;
                    areq  <= RESET_PC;
                    fpc   <= RESET_PC;
                    if (!stall_in) begin
                        iout      <= 32'd0;
                        valid_out <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (br_take) begin
                        iout      <= 32'd0;
                        valid_out <= 1'b0;
                        // An ack this cycle is wrong-path; otherwise wait it out.
                        if (imem_ack) areq  <= br_target;
                        else          state <= ST_DRAIN;
                    end else if (imem_ack && stall_in) begin
                        skid  <= imem_rdata;
                        state <= ST_HOLD;
                    end else if (imem_ack) begin
                        iout      <= imem_rdata;
                        pc_out    <= areq;
                        valid_out <= 1'b1;
                        areq      <= areq + 32'd4;
                        fpc       <= areq + 32'd4;
                    end else if (!stall_in) begin
                        iout      <= 32'd0;
                        valid_out <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (br_take) begin
                        iout      <= 32'd0;
                        valid_out <= 1'b0;
                        areq      <= br_target;
                        state     <= ST_FETCH;
                    end else if (!stall_in) begin
                        iout      <= skid;
                        pc_out    <= areq;
                        valid_out <= 1'b1;
                        areq      <= areq + 32'd4;
                        fpc       <= areq + 32'd4;
                        state     <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (!stall_in) begin
                        iout      <= 32'd0;
                        valid_out <= 1'b0;
                    end
                    if (imem_ack) begin
                        areq  <= fpc;
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_START;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch32.sv
// Bench for ifetch32: directed cycle vectors, a flag-based reference model
// compared every cycle, plus literal spot checks.
module tb_ifetch32;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        ib_in;
    logic        bl_in;
    logic [31:0] bv_in;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] iout;
    logic [31:0] pc_out;
    logic        valid_out;
    logic [31:0] lr_out;
    logic        lr_we;

    int checks = 0;
    int errors = 0;
    logic check_en = 1'b0;

    ifetch32 #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .ib_in(ib_in),
        .bl_in(bl_in), .bv_in(bv_in), .imem_rdata(imem_rdata),
        .imem_ack(imem_ack), .imem_req(imem_req), .imem_addr(imem_addr),
        .iout(iout), .pc_out(pc_out), .valid_out(valid_out),
        .lr_out(lr_out), .lr_we(lr_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: flags describing what the fetch unit is doing.
    logic        m_live, m_hold, m_drop;
    logic [31:0] m_addr, m_redirect, m_skid;
    logic [31:0] m_iw, m_ipc;
    logic        m_iv;
    logic [31:0] m_lr;
    logic        m_lrwe;
    logic        m_take, m_got;
    logic [31:0] m_tgt;

    function automatic logic m_req();
        return m_live && !m_hold;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_live = 0; m_hold = 0; m_drop = 0;
            m_addr = RST_PC; m_redirect = RST_PC; m_skid = 0;
            m_iw = 0; m_ipc = 0; m_iv = 0; m_lr = 0; m_lrwe = 0;
        end else if (!m_live) begin
            m_live = 1;
            m_addr = RST_PC;
            m_lrwe = 0;
            if (!stall_in) begin m_iv = 0; m_iw = 0; end
        end else begin
            m_take = ib_in && m_iv && !stall_in;
            m_tgt  = m_ipc + 32'd8 + bv_in;
            m_got  = imem_ack && m_req();
            m_lrwe = m_take && bl_in;
            if (m_take) m_lr = m_ipc + 32'd4;
            if (m_take) begin
                m_iv = 0; m_iw = 0; m_redirect = m_tgt;
                if (m_hold) begin m_hold = 0; m_addr = m_tgt; end
                else if (m_got) m_addr = m_tgt;
                else m_drop = 1;
            end else if (m_hold) begin
                if (!stall_in) begin
                    m_iw = m_skid; m_ipc = m_addr; m_iv = 1;
                    m_addr = m_addr + 32'd4; m_hold = 0;
                end
            end else if (m_got && m_drop) begin
                m_drop = 0; m_addr = m_redirect;
                if (!stall_in) begin m_iv = 0; m_iw = 0; end
            end else if (m_got && stall_in) begin
                m_skid = imem_rdata; m_hold = 1;
            end else if (m_got) begin
                m_iw = imem_rdata; m_ipc = m_addr; m_iv = 1;
                m_addr = m_addr + 32'd4;
            end else if (!stall_in) begin
                m_iv = 0; m_iw = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("imem_req", {31'd0, imem_req}, {31'd0, m_req()});
            chk("imem_addr", imem_addr, m_addr);
            chk("valid_out", {31'd0, valid_out}, {31'd0, m_iv});
            chk("iout", iout, m_iw);
            if (m_iv) chk("pc_out", pc_out, m_ipc);
            chk("lr_out", lr_out, m_lr);
            chk("lr_we", {31'd0, lr_we}, {31'd0, m_lrwe});
        end
    end

    task automatic step(input logic rst, input logic st, input logic ib, input logic bl,
                        input logic [31:0] bv, input logic ack);
        reset = rst; stall_in = st; ib_in = ib; bl_in = bl; bv_in = bv;
        imem_ack = ack;
        imem_rdata = ack ? word_of(m_addr) : 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1; stall_in = 0; ib_in = 0; bl_in = 0; bv_in = 0;
        imem_ack = 0; imem_rdata = 0;
        @(negedge clk);
        // Reset overrides a concurrent branch and ack.
        step(1, 0, 1, 1, 32'h40, 1);
        check_en = 1'b1;
        step(1, 0, 1, 1, 32'h40, 1);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h100);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_lr", lr_out, 32'd0);
        chk("rst_lrwe", {31'd0, lr_we}, 32'd0);

        step(0, 0, 0, 0, 0, 0);
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h100);

        // Back-to-back acks.
        step(0, 0, 0, 0, 0, 1);
        chk("seq_pc0", pc_out, 32'h100);
        chk("seq_iout0", iout, word_of(32'h100));
        chk("seq_addr1", imem_addr, 32'h104);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("seq_pc2", pc_out, 32'h108);
        chk("seq_addr3", imem_addr, 32'h10C);

        // Non-linking branch to 0x200, then linking branch 0x200 -> 0x248.
        step(0, 0, 1, 0, 32'h0000_00F0, 1);
        chk("br1_addr", imem_addr, 32'h200);
        chk("br1_valid", {31'd0, valid_out}, 32'd0);
        step(0, 0, 0, 0, 0, 1);
        chk("br2_pc", pc_out, 32'h200);
        step(0, 0, 1, 1, 32'h40, 1);
        chk("bl_addr", imem_addr, 32'h248);
        chk("bl_lr", lr_out, 32'h204);
        chk("bl_we", {31'd0, lr_we}, 32'd1);
        chk("bl_bubble", {31'd0, valid_out}, 32'd0);
        step(0, 0, 0, 0, 0, 1);
        chk("bl_we_off", {31'd0, lr_we}, 32'd0);
        chk("tgt_pc", pc_out, 32'h248);

        // Branch while request outstanding -> drain old address.
        step(0, 0, 1, 0, 32'h0000_01B0, 0);
        chk("drain_addr", imem_addr, 32'h24C);
        chk("drain_req", {31'd0, imem_req}, 32'd1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("drain_hold", imem_addr, 32'h24C);
        step(0, 0, 0, 0, 0, 1);
        chk("drain_done", imem_addr, 32'h400);
        chk("drain_nov", {31'd0, valid_out}, 32'd0);
        step(0, 0, 0, 0, 0, 1);
        chk("drain_tgt", pc_out, 32'h400);

        // Stall for 4 cycles as an ack lands; branch request ignored while stalled.
        step(0, 1, 0, 0, 0, 1);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_pc", pc_out, 32'h400);
        step(0, 1, 1, 1, 32'h80, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("hold_frz", pc_out, 32'h400);
        chk("hold_nolr", {31'd0, lr_we}, 32'd0);
        step(0, 0, 0, 0, 0, 0);
        chk("rel_pc", pc_out, 32'h404);
        chk("rel_iout", iout, word_of(32'h404));
        chk("rel_addr", imem_addr, 32'h408);
        step(0, 0, 0, 0, 0, 1);
        chk("rel_next", pc_out, 32'h408);

        // Target wraps past 2^32.
        step(0, 0, 1, 0, 32'hFFFF_FBE8, 1);
        chk("wrap_pre", imem_addr, 32'hFFFF_FFF8);
        step(0, 0, 0, 0, 0, 1);
        chk("wrap_pc", pc_out, 32'hFFFF_FFF8);
        step(0, 0, 1, 1, 32'h10, 1);
        chk("wrap_tgt", imem_addr, 32'h0000_0010);
        chk("wrap_lr", lr_out, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 1);
        chk("wrap_pc2", pc_out, 32'h10);

        // Reset in DRAIN, ack in the following START cycle is ignored.
        step(0, 0, 1, 0, 32'h20, 0);
        chk("d2_addr", imem_addr, 32'h14);
        step(1, 0, 0, 0, 0, 0);
        chk("r2_req", {31'd0, imem_req}, 32'd0);
        chk("r2_addr", imem_addr, 32'h100);
        chk("r2_lr", lr_out, 32'd0);
        step(0, 0, 0, 0, 0, 1);
        chk("r2_start", imem_addr, 32'h100);
        chk("r2_nov", {31'd0, valid_out}, 32'd0);
        step(0, 0, 0, 0, 0, 1);
        chk("r2_pc", pc_out, 32'h100);
        step(0, 0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch32.md
# ifetch32

Instruction fetch stage for the 32-bit core. It owns the program counter, issues requests to instruction memory over a req/ack handshake, and holds the fetched word in the IF/ID register that drives the instruction decoder. It consumes the decoder's branch outputs (`ib`, `bv`, `bl`) to redirect fetch, squash wrong-path words and produce the r14 link value.

## Interface

- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `stall_in`  in  1  downstream hold; when high, the IF/ID register must not change
- `ib_in`  in  1  decoder: take branch for the instruction currently in IF/ID
- `bl_in`  in  1  decoder: branch links (write r14)
- `bv_in`  in  32  decoder: sign-extended, word-shifted branch offset
- `imem_rdata`  in  32  instruction memory read data, valid when `imem_ack` is high
- `imem_ack`  in  1  instruction memory response strobe
- `imem_req`  out  1  fetch request; held high until acked
- `imem_addr`  out  32  fetch address; stable while `imem_req` is high
- `iout`  out  32  IF/ID instruction to the decoder; 0 (no-op) when invalid
- `pc_out`  out  32  address of `iout`
- `valid_out`  out  1  IF/ID holds a real instruction
- `lr_out`  out  32  link value for r14
- `lr_we`  out  1  one-cycle r14 write strobe

## Operation

- Registers: `fpc` (next fetch address), `areq` (address of the outstanding request, drives `imem_addr`), IF/ID (`iout`, `pc_out`, `valid_out`), one-word skid buffer, FSM.
- FSM states: START, FETCH, HOLD, DRAIN.
- START: entered on reset. `imem_req`=0, acks ignored. Next state is FETCH, with `areq`=`fpc`=RESET_PC.
- FETCH: `imem_req`=1, `imem_addr`=`areq`.
  - On ack with `stall_in`=0 and no branch: IF/ID <= {`imem_rdata`, `areq`, 1}. `fpc` and `areq` <= `areq`+4. Stay in FETCH.
  - On ack with `stall_in`=1: word goes to the skid buffer and the state moves to HOLD.
  - With no ack and `stall_in`=0, IF/ID is loaded as a bubble (`valid_out`=0, `iout`=0).
- HOLD: `imem_req`=0. When `stall_in` falls, the skid word moves into IF/ID, `areq` advances by 4, and the state moves to FETCH.
- Branch acceptance: a branch is accepted only when `ib_in`=1, `valid_out`=1 and `stall_in`=0. It is ignored otherwise.
- Branch target: `pc_out` + 8 + `bv_in`, computed mod 2^32 (wraps, no overflow flag).
- On an accepted branch:
  - IF/ID is loaded with a bubble.
  - `fpc` <= target.
  - `lr_out` <= `pc_out`+4. `lr_we` <= `bl_in`.
  - From FETCH with ack this cycle: the acked word is discarded, `areq` <= target, stay in FETCH.
  - From FETCH with no ack: go to DRAIN. `areq` keeps the old address.
  - From HOLD: the skid word is discarded, `areq` <= target, go to FETCH.
- DRAIN: `imem_req`=1 at the old `areq`. On ack the data is discarded, `areq` <= `fpc`, and the state moves to FETCH. IF/ID shows bubbles meanwhile. A second branch cannot arrive because `valid_out`=0.
- `lr_we` is high for exactly one cycle per accepted linking branch, and 0 otherwise. `lr_out` holds its last value.

## Timing

- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `iout`=0, `pc_out`=0, `valid_out`=0, `lr_out`=0, `lr_we`=0. State = START.
- Reset is synchronous and overrides everything, including a branch or ack in the same cycle. Mid-transaction reset abandons the outstanding request; any ack during START is ignored.
- First `imem_req` is in the cycle after reset deasserts.
- Fetch latency: ack in cycle N puts the word on `iout` with `valid_out`=1 in cycle N+1.
- `imem_ack` is permitted in the same cycle `imem_req` first rises. Throughput is 1 instruction/cycle with single-cycle acks.
- Branch penalty: branch in IF/ID at cycle N means cycle N+1 is a bubble with `imem_addr`=target and `lr_we` pulsed. With an immediate ack, the target instruction appears at N+2.
- `stall_in` freezes `iout`, `pc_out` and `valid_out` in the same cycle it is high.

## Test plan

- Reset, RESET_PC=0x100, ack every cycle → `imem_addr` 0x100, 0x104, 0x108; `iout`/`pc_out` follow one cycle later with `valid_out`=1.
- Word at `pc_out`=0x200 with `ib_in`=1, `bl_in`=1, `bv_in`=0x40 → next cycle `imem_addr`=0x248, bubble, `lr_out`=0x204, `lr_we`=1 for one cycle.
- Ack delayed 3 cycles, branch accepted while a request is outstanding → state DRAIN, old address held until ack, data dropped, then fetch at target; no wrong-path `valid_out`.
- `stall_in` high for 4 cycles as an ack arrives → IF/ID frozen, `imem_req`=0 in HOLD; on release the buffered word appears and fetch resumes at the next word with no loss or duplication.
- `pc_out`=0xFFFF_FFF8, `bv_in`=0x10, branch taken → target 0x0000_0010 (wrap).
- Reset asserted in DRAIN with an ack on the following cycle → ack ignored, fetch restarts at RESET_PC, all outputs at reset values.
